// File: rtl/vector_memory_arbiter.sv
// vector_memory_arbiter
//
// Shares the single vector data memory between the CPU memory stage and a
// host burst port. The host loads vector operands before a run and reads
// results back afterwards. The memory outputs are a combinational mux of the
// current owner's address, write enable and data.
//
// When a burst is active and both sides want memory, ownership alternates.
// A contended CPU therefore waits at most one cycle. The first contested
// cycle after a burst starts goes to the CPU.
//
// Ports
//   clock, reset        system clock, asynchronous active-low reset
//   cpuRequest/cpuWrite M-stage access request and direction
//   cpuAddress          CPU word address
//   cpuWriteData        CPU store data
//   cpuReadData         combinational pass-through of memReadData
//   cpuStall            CPU requested but lost the cycle
//   hostStart           burst command strobe (accepted only when hostReady)
//   hostWrite           burst direction, sampled with hostStart
//   hostBaseAddress     first burst address
//   hostLength          burst length in beats
//   hostReady           command can be accepted (IDLE)
//   hostBeatValid       write beat data present
//   hostBeatData        write beat data
//   hostBeatReady       write beat consumed this cycle
//   hostReadData        registered read beat
//   hostReadValid       hostReadData valid, one pulse per beat
//   hostDone            one-cycle pulse at burst end
//   hostError           one-cycle pulse, zero-length command rejected
//   memWriteEnable      memory write strobe
//   memAddress          memory read/write address
//   memWriteData        memory write data
//   memReadData         memory asynchronous read data

module vector_memory_arbiter #(
   parameter int unsigned DATA_WIDTH    = 16,
   parameter int unsigned VECTOR_SIZE   = 6,
   parameter int unsigned ADDRESS_WIDTH = 16,
   parameter int unsigned LEN_WIDTH     = 8
) (
   input  logic                              clock,
   input  logic                              reset,
   // CPU memory stage
   input  logic                              cpuRequest,
   input  logic                              cpuWrite,
   input  logic [ADDRESS_WIDTH-1:0]          cpuAddress,
   input  logic [DATA_WIDTH*VECTOR_SIZE-1:0] cpuWriteData,
   output logic [DATA_WIDTH*VECTOR_SIZE-1:0] cpuReadData,
   output logic                              cpuStall,
   // Host burst port
   input  logic                              hostStart,
   input  logic                              hostWrite,
   input  logic [ADDRESS_WIDTH-1:0]          hostBaseAddress,
   input  logic [LEN_WIDTH-1:0]              hostLength,
   output logic                              hostReady,
   input  logic                              hostBeatValid,
   input  logic [DATA_WIDTH*VECTOR_SIZE-1:0] hostBeatData,
   output logic                              hostBeatReady,
   output logic [DATA_WIDTH*VECTOR_SIZE-1:0] hostReadData,
   output logic                              hostReadValid,
   output logic                              hostDone,
   output logic                              hostError,
   // Memory macro
   output logic                              memWriteEnable,
   output logic [ADDRESS_WIDTH-1:0]          memAddress,
   output logic [DATA_WIDTH*VECTOR_SIZE-1:0] memWriteData,
   input  logic [DATA_WIDTH*VECTOR_SIZE-1:0] memReadData
);

   localparam int unsigned WordWidth = DATA_WIDTH * VECTOR_SIZE;

   typedef enum logic [1:0] {
      StIdle,
      StBurst,
      StDone
   } state_e;

   localparam logic OwnerCpu  = 1'b0;
   localparam logic OwnerHost = 1'b1;

   // State
   state_e                   state_q, state_d;
   logic [LEN_WIDTH-1:0]     beat_q, beat_d;
   logic [LEN_WIDTH-1:0]     len_q, len_d;
   logic [ADDRESS_WIDTH-1:0] base_q, base_d;
   logic                     write_q, write_d;
   logic                     last_owner_q, last_owner_d;
   logic [WordWidth-1:0]     read_data_q, read_data_d;
   logic                     read_valid_q, read_valid_d;
   logic                     done_q, done_d;
   logic                     error_q, error_d;

   // Arbitration
   logic                     host_eligible;
   logic                     cpu_grant;
   logic                     host_grant;
   logic                     last_beat;
   logic [ADDRESS_WIDTH-1:0] host_address;

   // Grant decision. Outside a burst the CPU always owns memory. Inside a
   // burst the CPU wins unless it had the previous granted access and the
   // host is able to use this cycle.
   always_comb begin
      host_eligible = 1'b0;
      cpu_grant     = cpuRequest;
      if (state_q == StBurst) begin
         // A read beat can always proceed; a write beat needs data
         host_eligible = !write_q || hostBeatValid;
         cpu_grant     = cpuRequest && ((last_owner_q == OwnerHost) || !host_eligible);
      end
      host_grant   = host_eligible && !cpu_grant;
      last_beat    = (beat_q == (len_q - LEN_WIDTH'(1)));
      // Wraps modulo 2^ADDRESS_WIDTH
      host_address = base_q + ADDRESS_WIDTH'(beat_q);
   end

   // Memory mux and combinational outputs
   always_comb begin
      if (host_grant) begin
         memAddress     = host_address;
         memWriteEnable = write_q;
         memWriteData   = hostBeatData;
      end else begin
         // Default address follows the CPU even with no access
         memAddress     = cpuAddress;
         memWriteEnable = cpu_grant && cpuWrite;
         memWriteData   = cpuWriteData;
      end
      cpuReadData   = memReadData;
      cpuStall      = cpuRequest && !cpu_grant;
      hostReady     = (state_q == StIdle);
      hostBeatReady = host_grant && write_q;
      hostReadData  = read_data_q;
      hostReadValid = read_valid_q;
      hostDone      = done_q;
      hostError     = error_q;
   end

   // Next-state logic
   always_comb begin
      state_d      = state_q;
      beat_d       = beat_q;
      len_d        = len_q;
      base_d       = base_q;
      write_d      = write_q;
      last_owner_d = last_owner_q;
      read_data_d  = read_data_q;
      read_valid_d = 1'b0;
      done_d       = 1'b0;
      error_d      = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (hostStart) begin
               if (hostLength == '0) begin
                  error_d = 1'b1;
               end else begin
                  write_d      = hostWrite;
                  base_d       = hostBaseAddress;
                  len_d        = hostLength;
                  beat_d       = '0;
                  last_owner_d = OwnerHost;
                  state_d      = StBurst;
               end
            end
         end

         StBurst: begin
            if (cpu_grant) begin
               last_owner_d = OwnerCpu;
            end else if (host_grant) begin
               last_owner_d = OwnerHost;
               beat_d       = beat_q + LEN_WIDTH'(1);
               if (!write_q) begin
                  read_data_d  = memReadData;
                  read_valid_d = 1'b1;
               end
               if (last_beat) begin
                  // done_q is high for exactly the DONE cycle
                  state_d = StDone;
                  done_d  = 1'b1;
               end
            end
         end

         StDone: begin
            state_d = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= StIdle;
         beat_q       <= '0;
         len_q        <= '0;
         base_q       <= '0;
         write_q      <= 1'b0;
         last_owner_q <= OwnerHost;
         read_data_q  <= '0;
         read_valid_q <= 1'b0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         beat_q       <= beat_d;
         len_q        <= len_d;
         base_q       <= base_d;
         write_q      <= write_d;
         last_owner_q <= last_owner_d;
         read_data_q  <= read_data_d;
         read_valid_q <= read_valid_d;
         done_q       <= done_d;
         error_q      <= error_d;
      end
   end

endmodule

// File: tb/tb_vector_memory_arbiter.sv
// Directed testbench for vector_memory_arbiter with a behavioural memory.

module tb_vector_memory_arbiter;

   localparam int unsigned DW = 16;
   localparam int unsigned VS = 6;
   localparam int unsigned AW = 16;
   localparam int unsigned LW = 8;
   localparam int unsigned WW = DW * VS;

   logic          clock;
   logic          reset;
   logic          cpuRequest;
   logic          cpuWrite;
   logic [AW-1:0] cpuAddress;
   logic [WW-1:0] cpuWriteData;
   logic [WW-1:0] cpuReadData;
   logic          cpuStall;
   logic          hostStart;
   logic          hostWrite;
   logic [AW-1:0] hostBaseAddress;
   logic [LW-1:0] hostLength;
   logic          hostReady;
   logic          hostBeatValid;
   logic [WW-1:0] hostBeatData;
   logic          hostBeatReady;
   logic [WW-1:0] hostReadData;
   logic          hostReadValid;
   logic          hostDone;
   logic          hostError;
   logic          memWriteEnable;
   logic [AW-1:0] memAddress;
   logic [WW-1:0] memWriteData;
   logic [WW-1:0] memReadData;

   int vectors     = 0;
   int miscompares = 0;
   int hits_0100   = 0;

   logic [WW-1:0] mem [0:65535];

   vector_memory_arbiter #(
      .DATA_WIDTH   (DW),
      .VECTOR_SIZE  (VS),
      .ADDRESS_WIDTH(AW),
      .LEN_WIDTH    (LW)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .cpuRequest     (cpuRequest),
      .cpuWrite       (cpuWrite),
      .cpuAddress     (cpuAddress),
      .cpuWriteData   (cpuWriteData),
      .cpuReadData    (cpuReadData),
      .cpuStall       (cpuStall),
      .hostStart      (hostStart),
      .hostWrite      (hostWrite),
      .hostBaseAddress(hostBaseAddress),
      .hostLength     (hostLength),
      .hostReady      (hostReady),
      .hostBeatValid  (hostBeatValid),
      .hostBeatData   (hostBeatData),
      .hostBeatReady  (hostBeatReady),
      .hostReadData   (hostReadData),
      .hostReadValid  (hostReadValid),
      .hostDone       (hostDone),
      .hostError      (hostError),
      .memWriteEnable (memWriteEnable),
      .memAddress     (memAddress),
      .memWriteData   (memWriteData),
      .memReadData    (memReadData)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Behavioural memory: synchronous write, asynchronous read
   always @(posedge clock) begin
      if (memWriteEnable) begin
         mem[memAddress] <= memWriteData;
         if (memAddress == 16'h0100) hits_0100 <= hits_0100 + 1;
      end
   end
   assign memReadData = mem[memAddress];

   function automatic logic [WW-1:0] pat(input logic [15:0] a, input logic [15:0] tag);
      return {6{a ^ tag}};
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic cpu_store(input logic [AW-1:0] a, input logic [WW-1:0] d);
      cpuRequest   = 1'b1;
      cpuWrite     = 1'b1;
      cpuAddress   = a;
      cpuWriteData = d;
      tick();
      cpuRequest   = 1'b0;
      cpuWrite     = 1'b0;
   endtask

   task automatic test_reset();
      settle();
      vectors++; if (hostReady !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b want 1", hostReady); end
      vectors++; if (hostReadValid !== 1'b0) begin miscompares++; $display("FAIL reset_rvalid got %b want 0", hostReadValid); end
      vectors++; if (hostReadData !== '0) begin miscompares++; $display("FAIL reset_rdata got %h want 0", hostReadData); end
      vectors++; if (hostDone !== 1'b0 || hostError !== 1'b0) begin miscompares++; $display("FAIL reset_done_err got %b%b want 00", hostDone, hostError); end
      vectors++; if (memWriteEnable !== 1'b0) begin miscompares++; $display("FAIL reset_we got %b want 0", memWriteEnable); end
      tick();
      tick();
      reset = 1'b1;
      tick();
   endtask

   task automatic test_write_burst();
      hostStart = 1'b1; hostWrite = 1'b1; hostBaseAddress = 16'h0010; hostLength = 8'd3;
      hostBeatValid = 1'b1; hostBeatData = pat(16'h0010, 16'h1111);
      settle();
      vectors++; if (hostReady !== 1'b1) begin miscompares++; $display("FAIL wr_ready_idle got %b want 1", hostReady); end
      tick();
      hostStart = 1'b0;
      for (int i = 0; i < 3; i++) begin
         hostBeatData = pat(16'h0010 + 16'(i), 16'h1111);
         settle();
         vectors++; if (memWriteEnable !== 1'b1 || memAddress !== 16'h0010 + 16'(i)) begin
            miscompares++; $display("FAIL wr_beat%0d got we=%b addr=%h want we=1 addr=%h", i, memWriteEnable, memAddress, 16'h0010 + 16'(i)); end
         vectors++; if (hostBeatReady !== 1'b1 || hostReady !== 1'b0) begin
            miscompares++; $display("FAIL wr_beat%0d_hs got bready=%b ready=%b want 1 0", i, hostBeatReady, hostReady); end
         tick();
      end
      hostBeatValid = 1'b0;
      settle();
      vectors++; if (hostDone !== 1'b1 || memWriteEnable !== 1'b0 || hostReady !== 1'b0) begin
         miscompares++; $display("FAIL wr_done got done=%b we=%b ready=%b want 1 0 0", hostDone, memWriteEnable, hostReady); end
      tick();
      vectors++; if (hostDone !== 1'b0 || hostReady !== 1'b1) begin
         miscompares++; $display("FAIL wr_idle got done=%b ready=%b want 0 1", hostDone, hostReady); end
      for (int i = 0; i < 3; i++) begin
         vectors++; if (mem[16'h0010 + 16'(i)] !== pat(16'h0010 + 16'(i), 16'h1111)) begin
            miscompares++; $display("FAIL wr_mem%0d got %h want %h", i, mem[16'h0010 + 16'(i)], pat(16'h0010 + 16'(i), 16'h1111)); end
      end
   endtask

   task automatic test_read_interleave();
      logic [WW-1:0] d20;
      logic [WW-1:0] d21;
      d20 = pat(16'h0020, 16'hA5A5);
      d21 = pat(16'h0021, 16'h5A5A);
      cpu_store(16'h0020, d20);
      cpu_store(16'h0021, d21);
      hostStart = 1'b1; hostWrite = 1'b0; hostBaseAddress = 16'h0020; hostLength = 8'd2;
      cpuRequest = 1'b1; cpuWrite = 1'b0; cpuAddress = 16'h0040;
      tick();
      hostStart = 1'b0;
      settle();
      vectors++; if (cpuStall !== 1'b0 || memAddress !== 16'h0040) begin
         miscompares++; $display("FAIL rd_c1_cpu got stall=%b addr=%h want 0 0040", cpuStall, memAddress); end
      tick();
      settle();
      vectors++; if (cpuStall !== 1'b1 || memAddress !== 16'h0020 || memWriteEnable !== 1'b0) begin
         miscompares++; $display("FAIL rd_c2_host got stall=%b addr=%h we=%b want 1 0020 0", cpuStall, memAddress, memWriteEnable); end
      vectors++; if (hostReadValid !== 1'b0) begin miscompares++; $display("FAIL rd_c2_rvalid got %b want 0", hostReadValid); end
      tick();
      settle();
      vectors++; if (cpuStall !== 1'b0 || memAddress !== 16'h0040) begin
         miscompares++; $display("FAIL rd_c3_cpu got stall=%b addr=%h want 0 0040", cpuStall, memAddress); end
      vectors++; if (hostReadValid !== 1'b1 || hostReadData !== d20) begin
         miscompares++; $display("FAIL rd_beat0 got v=%b d=%h want 1 %h", hostReadValid, hostReadData, d20); end
      tick();
      settle();
      vectors++; if (cpuStall !== 1'b1 || memAddress !== 16'h0021) begin
         miscompares++; $display("FAIL rd_c4_host got stall=%b addr=%h want 1 0021", cpuStall, memAddress); end
      tick();
      settle();
      vectors++; if (hostDone !== 1'b1 || hostReadValid !== 1'b1 || hostReadData !== d21) begin
         miscompares++; $display("FAIL rd_done got done=%b v=%b d=%h want 1 1 %h", hostDone, hostReadValid, hostReadData, d21); end
      vectors++; if (cpuStall !== 1'b0) begin miscompares++; $display("FAIL rd_done_stall got %b want 0", cpuStall); end
      cpuRequest = 1'b0;
      tick();
      vectors++; if (hostReady !== 1'b1 || hostReadValid !== 1'b0) begin
         miscompares++; $display("FAIL rd_idle got ready=%b v=%b want 1 0", hostReady, hostReadValid); end
   endtask

   task automatic test_write_gaps();
      hostStart = 1'b1; hostWrite = 1'b1; hostBaseAddress = 16'h0030; hostLength = 8'd2;
      hostBeatValid = 1'b0;
      cpuRequest = 1'b1; cpuWrite = 1'b0; cpuAddress = 16'h0050;
      tick();
      hostStart = 1'b0;
      for (int i = 0; i < 2; i++) begin
         settle();
         vectors++; if (cpuStall !== 1'b0 || memAddress !== 16'h0050 || hostBeatReady !== 1'b0) begin
            miscompares++; $display("FAIL gap%0d got stall=%b addr=%h bready=%b want 0 0050 0", i, cpuStall, memAddress, hostBeatReady); end
         tick();
      end
      hostBeatValid = 1'b1; hostBeatData = pat(16'h0030, 16'h3C3C);
      settle();
      vectors++; if (cpuStall !== 1'b1 || memAddress !== 16'h0030 || hostBeatReady !== 1'b1) begin
         miscompares++; $display("FAIL gap_beat0 got stall=%b addr=%h bready=%b want 1 0030 1", cpuStall, memAddress, hostBeatReady); end
      tick();
      hostBeatData = pat(16'h0031, 16'h3C3C);
      settle();
      vectors++; if (cpuStall !== 1'b0 || hostBeatReady !== 1'b0 || memWriteEnable !== 1'b0) begin
         miscompares++; $display("FAIL gap_cpu_turn got stall=%b bready=%b we=%b want 0 0 0", cpuStall, hostBeatReady, memWriteEnable); end
      tick();
      settle();
      vectors++; if (cpuStall !== 1'b1 || memAddress !== 16'h0031 || memWriteEnable !== 1'b1) begin
         miscompares++; $display("FAIL gap_beat1 got stall=%b addr=%h we=%b want 1 0031 1", cpuStall, memAddress, memWriteEnable); end
      tick();
      cpuRequest = 1'b0; hostBeatValid = 1'b0;
      settle();
      vectors++; if (hostDone !== 1'b1) begin miscompares++; $display("FAIL gap_done got %b want 1", hostDone); end
      tick();
      vectors++; if (mem[16'h0030] !== pat(16'h0030, 16'h3C3C) || mem[16'h0031] !== pat(16'h0031, 16'h3C3C)) begin
         miscompares++; $display("FAIL gap_mem got %h %h", mem[16'h0030], mem[16'h0031]); end
   endtask

   task automatic test_zero_wrap();
      hostStart = 1'b1; hostWrite = 1'b1; hostBaseAddress = 16'h0060; hostLength = 8'd0;
      settle();
      vectors++; if (hostError !== 1'b0) begin miscompares++; $display("FAIL zl_err_early got %b want 0", hostError); end
      tick();
      hostStart = 1'b0;
      settle();
      vectors++; if (hostError !== 1'b1 || hostReady !== 1'b1 || memWriteEnable !== 1'b0) begin
         miscompares++; $display("FAIL zl_err got err=%b ready=%b we=%b want 1 1 0", hostError, hostReady, memWriteEnable); end
      tick();
      vectors++; if (hostError !== 1'b0 || hostReady !== 1'b1) begin
         miscompares++; $display("FAIL zl_after got err=%b ready=%b want 0 1", hostError, hostReady); end
      hostStart = 1'b1; hostBaseAddress = 16'hFFFF; hostLength = 8'd2;
      hostBeatValid = 1'b1; hostBeatData = pat(16'hFFFF, 16'h7777);
      tick();
      hostStart = 1'b0;
      settle();
      vectors++; if (memAddress !== 16'hFFFF || memWriteEnable !== 1'b1) begin
         miscompares++; $display("FAIL wrap_b0 got addr=%h we=%b want FFFF 1", memAddress, memWriteEnable); end
      tick();
      hostBeatData = pat(16'h0000, 16'h7777);
      settle();
      vectors++; if (memAddress !== 16'h0000 || memWriteEnable !== 1'b1) begin
         miscompares++; $display("FAIL wrap_b1 got addr=%h we=%b want 0000 1", memAddress, memWriteEnable); end
      tick();
      hostBeatValid = 1'b0;
      settle();
      vectors++; if (hostDone !== 1'b1 || hostError !== 1'b0) begin
         miscompares++; $display("FAIL wrap_done got done=%b err=%b want 1 0", hostDone, hostError); end
      tick();
      vectors++; if (mem[16'hFFFF] !== pat(16'hFFFF, 16'h7777) || mem[16'h0000] !== pat(16'h0000, 16'h7777)) begin
         miscompares++; $display("FAIL wrap_mem got %h %h", mem[16'hFFFF], mem[16'h0000]); end
   endtask

   task automatic test_busy_cmd();
      hostStart = 1'b1; hostWrite = 1'b1; hostBaseAddress = 16'h0070; hostLength = 8'd2;
      hostBeatValid = 1'b1; hostBeatData = pat(16'h0070, 16'h0F0F);
      tick();
      // Keep hammering a new command at 0x0100 through BURST and DONE
      hostBaseAddress = 16'h0100; hostLength = 8'd1;
      for (int i = 0; i < 2; i++) begin
         hostBeatData = pat(16'h0070 + 16'(i), 16'h0F0F);
         settle();
         vectors++; if (memAddress !== 16'h0070 + 16'(i) || hostError !== 1'b0) begin
            miscompares++; $display("FAIL busy_b%0d got addr=%h err=%b want %h 0", i, memAddress, hostError, 16'h0070 + 16'(i)); end
         tick();
      end
      hostBeatValid = 1'b0;
      settle();
      vectors++; if (hostDone !== 1'b1 || hostReady !== 1'b0) begin
         miscompares++; $display("FAIL busy_done got done=%b ready=%b want 1 0", hostDone, hostReady); end
      tick();
      hostStart = 1'b0;
      settle();
      vectors++; if (hostReady !== 1'b1 || hostError !== 1'b0 || memWriteEnable !== 1'b0) begin
         miscompares++; $display("FAIL busy_idle got ready=%b err=%b we=%b want 1 0 0", hostReady, hostError, memWriteEnable); end
      tick();
      tick();
      vectors++; if (hits_0100 !== 0 || hostReady !== 1'b1) begin
         miscompares++; $display("FAIL busy_0100 got hits=%0d ready=%b want 0 1", hits_0100, hostReady); end
   endtask

   task automatic test_reset_mid_burst();
      logic [WW-1:0] old2;
      logic [WW-1:0] old3;
      old2 = pat(16'h0082, 16'hDEAD);
      old3 = pat(16'h0083, 16'hBEEF);
      cpu_store(16'h0082, old2);
      cpu_store(16'h0083, old3);
      hostStart = 1'b1; hostWrite = 1'b1; hostBaseAddress = 16'h0080; hostLength = 8'd4;
      hostBeatValid = 1'b1; hostBeatData = pat(16'h0080, 16'h4444);
      tick();
      hostStart = 1'b0;
      tick();
      hostBeatData = pat(16'h0081, 16'h4444);
      settle();
      vectors++; if (memAddress !== 16'h0081 || memWriteEnable !== 1'b1) begin
         miscompares++; $display("FAIL rst_b1 got addr=%h we=%b want 0081 1", memAddress, memWriteEnable); end
      tick();
      hostBeatData = pat(16'h0082, 16'h4444);
      reset = 1'b0;
      settle();
      vectors++; if (memWriteEnable !== 1'b0 || hostBeatReady !== 1'b0) begin
         miscompares++; $display("FAIL rst_we got we=%b bready=%b want 0 0", memWriteEnable, hostBeatReady); end
      vectors++; if (hostReadData !== '0 || hostReadValid !== 1'b0 || hostDone !== 1'b0 || hostError !== 1'b0) begin
         miscompares++; $display("FAIL rst_regs got d=%h v=%b done=%b err=%b want 0", hostReadData, hostReadValid, hostDone, hostError); end
      vectors++; if (hostReady !== 1'b1) begin miscompares++; $display("FAIL rst_ready_now got %b want 1", hostReady); end
      tick();
      hostBeatValid = 1'b0;
      reset = 1'b1;
      tick();
      vectors++; if (hostReady !== 1'b1 || memWriteEnable !== 1'b0) begin
         miscompares++; $display("FAIL rst_ready_next got ready=%b we=%b want 1 0", hostReady, memWriteEnable); end
      vectors++; if (mem[16'h0082] !== old2 || mem[16'h0083] !== old3) begin
         miscompares++; $display("FAIL rst_unwritten got %h %h want %h %h", mem[16'h0082], mem[16'h0083], old2, old3); end
      vectors++; if (mem[16'h0080] !== pat(16'h0080, 16'h4444) || mem[16'h0081] !== pat(16'h0081, 16'h4444)) begin
         miscompares++; $display("FAIL rst_kept got %h %h", mem[16'h0080], mem[16'h0081]); end
   endtask

   initial begin
      reset           = 1'b0;
      cpuRequest      = 1'b0;
      cpuWrite        = 1'b0;
      cpuAddress      = '0;
      cpuWriteData    = '0;
      hostStart       = 1'b0;
      hostWrite       = 1'b0;
      hostBaseAddress = '0;
      hostLength      = '0;
      hostBeatValid   = 1'b0;
      hostBeatData    = '0;
      #1;
      test_reset();
      test_write_burst();
      test_read_interleave();
      test_write_gaps();
      test_zero_wrap();
      test_busy_cmd();
      test_reset_mid_burst();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/vector_memory_arbiter.md
Name: vector_memory_arbiter

Overview:
- Shares the single vector data memory between two requesters: the CPU memory stage and a host burst port.
- The host port loads vector operands before a run and reads results back afterwards.
- The block sits between the M-stage flip-flop outputs and the memory macro.
- It drives a stall to the hazard logic whenever the CPU loses a contested cycle.

Parameters:
DATA_WIDTH, 16, width of one vector element
VECTOR_SIZE, 6, elements per memory word; word width is DATA_WIDTH*VECTOR_SIZE
ADDRESS_WIDTH, 16, memory word address width
LEN_WIDTH, 8, width of the burst length field

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
cpuRequest  in  1  M-stage memory access this cycle
cpuWrite  in  1  1 = write, 0 = read
cpuAddress  in  ADDRESS_WIDTH  CPU word address
cpuWriteData  in  DATA_WIDTH*VECTOR_SIZE  CPU store data
cpuReadData  out  DATA_WIDTH*VECTOR_SIZE  combinational memReadData pass-through
cpuStall  out  1  cpuRequest && !CPU grant (combinational)
hostStart  in  1  burst command strobe
hostWrite  in  1  burst direction, sampled with hostStart
hostBaseAddress  in  ADDRESS_WIDTH  first burst address
hostLength  in  LEN_WIDTH  beat count, must be >= 1
hostReady  out  1  high in IDLE (command acceptable)
hostBeatValid  in  1  write beat data present
hostBeatData  in  DATA_WIDTH*VECTOR_SIZE  write beat data
hostBeatReady  out  1  write beat consumed this cycle
hostReadData  out  DATA_WIDTH*VECTOR_SIZE  registered read beat
hostReadValid  out  1  hostReadData valid (1-cycle pulse per beat)
hostDone  out  1  1-cycle pulse at burst end
hostError  out  1  1-cycle pulse, zero-length command rejected
memWriteEnable  out  1  memory write strobe
memAddress  out  ADDRESS_WIDTH  memory read/write address
memWriteData  out  DATA_WIDTH*VECTOR_SIZE  memory write data
memReadData  in  DATA_WIDTH*VECTOR_SIZE  memory asynchronous read data

Behaviour:
- Reset (reset=0, async): state IDLE, beat counter 0, lastOwner=HOST.
  - All registered outputs 0: hostReadData, hostReadValid, hostDone, hostError.
  - A partial burst is discarded. Beats already written stay in memory.
- Ownership each cycle is either CPU or HOST. The mem* outputs are a combinational mux of the owner's address, write enable and data.
  - With no owner access: memWriteEnable=0 and memAddress=cpuAddress.
- IDLE:
  - hostReady=1; the CPU always owns memory and cpuStall=0.
  - hostStart with hostLength=0: command ignored, hostError pulses next cycle.
  - hostStart with hostLength>=1: latch direction, base and length; beat=0; lastOwner:=HOST; next state BURST.
- BURST (hostReady=0):
  - Host eligible: read burst always; write burst only when hostBeatValid=1.
  - CPU granted if cpuRequest && (lastOwner==HOST || !hostEligible). Otherwise HOST is granted if eligible.
  - lastOwner updates only on a granted access.
  - Effect: a contended CPU waits at most 1 cycle, and the first contested cycle after burst start goes to the CPU.
- Host beat address = base + beat, modulo 2^ADDRESS_WIDTH (wraps, no error).
  - Write beat: memWriteEnable=1, memWriteData=hostBeatData, hostBeatReady=1.
  - Read beat: memReadData is registered into hostReadData; hostReadValid=1 on the next cycle.
  - beat increments on each host beat.
- When the beat granted at beat==length-1 completes: next state DONE.
- DONE:
  - Lasts 1 cycle; hostDone=1. For a read burst, the last hostReadValid coincides with this cycle.
  - The CPU owns memory as in IDLE; next state IDLE.
  - A hostStart in DONE is ignored (hostReady=0).
- hostStart outside IDLE is ignored, with no error.
- CPU read is combinational: cpuReadData=memReadData regardless of owner. It is meaningful only when cpuStall=0.
- The CPU must hold its request, address and data while cpuStall=1.

Test Plan:
- Reset mid-burst: write burst of length 4, assert reset after beat 1 → all outputs 0 immediately, state IDLE, hostReady=1 next cycle, addresses base+2/+3 unwritten.
- Write burst, no CPU traffic: base 0x0010, length 3, hostBeatValid held high → memWriteEnable on 3 consecutive cycles at 0x10/0x11/0x12, then hostDone 1 cycle, then hostReady=1.
- Read burst with interleaved CPU: base 0x0020, length 2, cpuRequest held high → grants CPU, HOST, CPU, HOST. cpuStall=1 on exactly the 2 HOST cycles; hostReadValid returns words 0x20 and 0x21.
- Write burst with gaps: hostBeatValid low for 2 cycles while cpuRequest=1 → CPU granted with cpuStall=0 during the gap; beat count unchanged.
- Zero length and wrap: hostLength=0 → hostError pulse, stays IDLE. Then base 0xFFFF, length 2 → writes 0xFFFF then 0x0000.
- Command while busy: hostStart during BURST or DONE with base 0x0100 → ignored, no error, no access to 0x0100.
